// File: rtl/mem_hs_pkg.sv
// Shared types and encodings for the mem_hs_ctrl 4-phase handshake responder.
package mem_hs_pkg;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_RTZ,
    ST_IDLE,
    ST_WR,
    ST_WR_HOLD,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_RD_RTZ
  } state_e;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;
  localparam logic [1:0] RW_BAD  = 2'b11;

endpackage

// File: rtl/mem_hs_sync.sv
// Parameterized-width 2-flop synchronizer; used by mem_hs_ctrl when MEM_HS_SYNC_EN is defined.
module mem_hs_sync #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_hs_ctrl.sv
// 4-phase req/ack responder driving a single-port synchronous SRAM; all outputs registered.
// Define MEM_HS_SYNC_EN to pass RW/RDataAck through 2-flop synchronizers (+2 cycles latency).
//   state      | meaning
//   ST_RTZ     | wait for RW==00 and RDataAck==00 before accepting requests
//   ST_IDLE    | sample RW; latch address/data and fire the SRAM strobe
//   ST_WR      | write strobe cycle; raise Ack/WdataAck next
//   ST_WR_HOLD | write acknowledged, wait for RW==00
//   ST_RD_WAIT | count down SRAM read latency, then capture data
//   ST_RD_HOLD | read data presented, wait for RDataAck==11 (RW==00 aborts)
//   ST_RD_RTZ  | wait for RW==00 and RDataAck==00 to drop Ack
module mem_hs_ctrl
  import mem_hs_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 131072,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic [1:0]        RW,
  input  logic [NIB_W-1:0]  W1,
  input  logic [NIB_W-1:0]  W2,
  output logic [1:0]        WdataAck,
  output logic [NIB_W-1:0]  R1,
  output logic [NIB_W-1:0]  R2,
  input  logic [1:0]        RDataAck,
  output logic              Ack,
  output logic              ERR,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [1:0] rw_s;
  logic [1:0] rdack_s;

`ifdef MEM_HS_SYNC_EN
  mem_hs_sync #(.W(4)) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   ({RW, RDataAck}),
    .q_o   ({rw_s, rdack_s})
  );
`else
  assign rw_s    = RW;
  assign rdack_s = RDataAck;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ce_q, ce_d, we_q, we_d;
  logic                ack_q, ack_d, err_q, err_d, oor_q, oor_d;
  logic [1:0]          wdack_q, wdack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         addr_ext;
  logic                in_range;

  assign addr_ext = 32'(A);
  assign in_range = addr_ext < DEPTH_U;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RTZ;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
      wdack_q <= 2'b00;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
      wdack_q <= wdack_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RTZ:     if (rw_s == RW_IDLE && rdack_s == 2'b00) state_d = ST_IDLE;
      ST_IDLE: begin
        if (rw_s == RW_WR)      state_d = ST_WR;
        else if (rw_s == RW_RD) state_d = ST_RD_WAIT;
      end
      ST_WR:      state_d = ST_WR_HOLD;
      ST_WR_HOLD: if (rw_s == RW_IDLE) state_d = ST_IDLE;
      ST_RD_WAIT: if (cnt_q == '0) state_d = ST_RD_HOLD;
      ST_RD_HOLD: begin
        if (rdack_s == 2'b11)     state_d = ST_RD_RTZ;
        else if (rw_s == RW_IDLE) state_d = ST_RTZ;
      end
      ST_RD_RTZ:  if (rw_s == RW_IDLE && rdack_s == 2'b00) state_d = ST_IDLE;
      default:    state_d = ST_RTZ;
    endcase
  end

  always_comb begin
    ce_d    = 1'b0;
    we_d    = 1'b0;
    ack_d   = ack_q;
    err_d   = err_q;
    oor_d   = oor_q;
    wdack_d = wdack_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rw_s == RW_WR || rw_s == RW_RD) begin
          addr_d = A;
          oor_d  = !in_range;
          ce_d   = in_range;
          we_d   = in_range && (rw_s == RW_WR);
          err_d  = err_q | !in_range;
          if (rw_s == RW_WR) wdata_d = {W2, W1};
          else               cnt_d   = CNT_W'(RD_LAT);
        end else if (rw_s == RW_BAD) begin
          err_d = 1'b1;
        end
      end
      ST_WR: begin
        ack_d   = 1'b1;
        wdack_d = 2'b11;
      end
      ST_WR_HOLD: begin
        if (rw_s == RW_IDLE) begin
          ack_d   = 1'b0;
          wdack_d = 2'b00;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          ack_d   = 1'b1;
          rdata_d = oor_q ? '0 : sram_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Requester dropped RW before taking the data: abort and resync via RTZ.
      ST_RD_HOLD: begin
        if (rdack_s != 2'b11 && rw_s == RW_IDLE) begin
          ack_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_RD_RTZ: begin
        if (rw_s == RW_IDLE && rdack_s == 2'b00) begin
          ack_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign Ack        = ack_q;
  assign ERR        = err_q;
  assign WdataAck   = wdack_q;
  assign R1         = rdata_q[NIB_W-1:0];
  assign R2         = rdata_q[DATA_W-1:NIB_W];
  assign sram_ce    = ce_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_hs_ctrl.sv
// Scoreboard bench for mem_hs_ctrl: directed handshake scenarios plus randomized traffic.
module tb_mem_hs_ctrl;
  import mem_hs_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 'h18000;
  localparam int RD_LAT = 2;
`ifdef MEM_HS_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [ADDR_W-1:0] A = '0;
  logic [1:0]        RW = 2'b00;
  logic [3:0]        W1 = '0;
  logic [3:0]        W2 = '0;
  logic [1:0]        RDataAck = 2'b00;
  logic [1:0]        WdataAck;
  logic [3:0]        R1, R2;
  logic              Ack, ERR, sram_ce, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata, sram_rdata;

  mem_hs_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .A(A), .RW(RW), .W1(W1), .W2(W2),
    .WdataAck(WdataAck), .R1(R1), .R2(R2), .RDataAck(RDataAck),
    .Ack(Ack), .ERR(ERR), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Unwritten SRAM words hold a known address-derived pattern.
  function automatic logic [7:0] init_word(logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] sram_arr [0:131071];
  bit         sram_vld [0:131071];
  logic [7:0] rd_pipe  [0:RD_LAT-1];

  always @(posedge CLK) begin
    if (sram_ce && sram_we) begin
      sram_arr[sram_addr] <= sram_wdata;
      sram_vld[sram_addr] <= 1'b1;
    end
    if (sram_ce && !sram_we)
      rd_pipe[0] <= sram_vld[sram_addr] ? sram_arr[sram_addr] : init_word(sram_addr);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  // Reference model: plain memory contents plus the sticky error flag.
  logic [7:0] ref_mem [int];
  bit         err_exp = 1'b0;

  function automatic logic [7:0] ref_read(logic [ADDR_W-1:0] a);
    if (32'(a) >= DEPTH) return 8'h00;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  typedef struct { int cyc; logic we; logic [ADDR_W-1:0] addr; logic [7:0] wdata; } strobe_t;
  typedef struct { int cyc; logic [1:0] wdack; logic [7:0] rdata; logic err; } resp_t;
  typedef struct { int cyc; logic err; } fall_t;

  strobe_t stb_q [$];
  resp_t   rsp_q [$];
  fall_t   fall_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic ack_prev = 1'b0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (sram_ce) begin
        if (stb_q.size() == 0) chk("unexpected_strobe", 32'(sram_ce), 32'd0);
        else begin
          chk("strobe_cycle", 32'(cyc), 32'(stb_q[0].cyc));
          chk("strobe_we_addr", 32'({sram_we, sram_addr}), 32'({stb_q[0].we, stb_q[0].addr}));
          if (stb_q[0].we) chk("strobe_wdata", 32'(sram_wdata), 32'(stb_q[0].wdata));
          stb_q.delete(0);
        end
      end
      if (Ack && !ack_prev) begin
        if (rsp_q.size() == 0) chk("unexpected_ack", 32'(Ack), 32'd0);
        else begin
          chk("ack_cycle", 32'(cyc), 32'(rsp_q[0].cyc));
          chk("ack_wdack", 32'(WdataAck), 32'(rsp_q[0].wdack));
          chk("ack_rdata", 32'({R2, R1}), 32'(rsp_q[0].rdata));
          chk("ack_err", 32'(ERR), 32'(rsp_q[0].err));
          rsp_q.delete(0);
        end
      end
      if (!Ack && ack_prev) begin
        if (fall_q.size() == 0) chk("unexpected_fall", 32'(Ack), 32'd1);
        else begin
          chk("fall_cycle", 32'(cyc), 32'(fall_q[0].cyc));
          chk("fall_outputs", 32'({WdataAck, R2, R1}), 32'd0);
          chk("fall_err", 32'(ERR), 32'(fall_q[0].err));
          fall_q.delete(0);
        end
      end
    end
    ack_prev <= RST ? 1'b0 : Ack;
  end

  task automatic wait_ack(logic v);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (Ack == v) return;
    end
    chk("ack_timeout", 32'(Ack), 32'(v));
  endtask

  task automatic do_write(logic [ADDR_W-1:0] a, logic [7:0] d);
    int smp;
    @(negedge CLK);
    A = a; W1 = d[3:0]; W2 = d[7:4]; RW = RW_WR;
    smp = cyc + 1 + SD;
    if (32'(a) < DEPTH) begin
      stb_q.push_back('{smp, 1'b1, a, d});
      ref_mem[int'(a)] = d;
    end else err_exp = 1'b1;
    rsp_q.push_back('{smp + 1, 2'b11, 8'h00, err_exp});
    wait_ack(1'b1);
    RW = RW_IDLE;
    fall_q.push_back('{cyc + 1 + SD, err_exp});
    wait_ack(1'b0);
  endtask

  task automatic do_read(logic [ADDR_W-1:0] a, bit abort);
    int smp;
    @(negedge CLK);
    A = a; RW = RW_RD;
    smp = cyc + 1 + SD;
    if (32'(a) < DEPTH) stb_q.push_back('{smp, 1'b0, a, 8'h00});
    else err_exp = 1'b1;
    rsp_q.push_back('{smp + 1 + RD_LAT, 2'b00, ref_read(a), err_exp});
    wait_ack(1'b1);
    if (abort) begin
      RW = RW_IDLE;
      err_exp = 1'b1;
      fall_q.push_back('{cyc + 1 + SD, 1'b1});
      wait_ack(1'b0);
      repeat (2 + SD) @(negedge CLK);
    end else begin
      RDataAck = 2'b11;
      repeat (1 + SD) @(negedge CLK);
      RW = RW_IDLE; RDataAck = 2'b00;
      fall_q.push_back('{cyc + 1 + SD, err_exp});
      wait_ack(1'b0);
    end
  endtask

  task automatic do_illegal();
    @(negedge CLK);
    RW = RW_BAD;
    err_exp = 1'b1;
    @(negedge CLK);
    RW = RW_IDLE;
    repeat (SD + 1) @(negedge CLK);
    chk("illegal_err", 32'(ERR), 32'd1);
  endtask

  task automatic do_reset_mid_read(logic [ADDR_W-1:0] a);
    int smp;
    @(negedge CLK);
    A = a; RW = RW_RD;
    smp = cyc + 1 + SD;
    stb_q.push_back('{smp, 1'b0, a, 8'h00});
    repeat (2 + SD) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    err_exp = 1'b0;
    chk("reset_mid_outputs", 32'({Ack, ERR, sram_ce, sram_we, WdataAck, R2, R1}), 32'd0);
    repeat (6 + SD) @(negedge CLK);
    RW = RW_IDLE;
    repeat (2 + SD) @(negedge CLK);
    do_read(a, 1'b0);
  endtask

  logic [ADDR_W-1:0] pool [0:7] = '{17'h00000, 17'h00001, 17'h0ABCD, 17'h11111,
                                    17'h17FFF, 17'h18000, 17'h1FFFF, 17'h12345};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'({Ack, ERR, sram_ce, sram_we, WdataAck, R2, R1}), 32'd0);
    RST = 1'b0;

    do_write(17'h11111, 8'h11);
    do_read(17'h11111, 1'b0);
    do_write(17'h18020, 8'hA5);
    do_read(17'h18020, 1'b0);
    do_illegal();
    do_write(17'h00005, 8'h3C);
    do_read(17'h00005, 1'b0);
    do_reset_mid_read(17'h11111);
    do_read(17'h17FFF, 1'b1);
    do_read(17'h00006, 1'b0);

    for (int t = 0; t < 48; t++) begin
      int k;
      logic [ADDR_W-1:0] a;
      k = $urandom_range(9);
      a = pool[$urandom_range(7)];
      if (k <= 3)      do_write(a, 8'($urandom));
      else if (k <= 7) do_read(a, 1'b0);
      else if (k == 8) do_illegal();
      else             do_read(a, 1'b1);
    end

    repeat (4) @(negedge CLK);
    chk("final_err", 32'(ERR), 32'(err_exp));
    chk("leftover_expectations", 32'(stb_q.size() + rsp_q.size() + fall_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_hs_ctrl.md
# mem_hs_ctrl

Memory-side responder for the 4-phase request/acknowledge bus that the `Write_Tb` stimulus drives: it consumes `A`/`RW`/`W1`/`W2`, performs the access on a single-port synchronous SRAM macro, and returns `Ack`, `WdataAck` and read data on `R1`/`R2`. It sits directly downstream of the requester in the 16nm test chip. It converts the level-based return-to-zero protocol into single-cycle SRAM strobes.

## Interface
- `ADDR_W`, 17, request address width.
- `DEPTH`, 131072, SRAM words; addresses `>= DEPTH` are out of range.
- `RD_LAT`, 1, SRAM read latency in cycles (1–4).
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `A`  in  ADDR_W  request address.
- `RW`  in  2  request code: 00 idle/RTZ, 01 write, 10 read, 11 illegal.
- `W1`, `W2`  in  4 each  write nibbles; SRAM word is {W2,W1}.
- `WdataAck`  out  2  per-nibble write-data acknowledge.
- `R1`, `R2`  out  4 each  read nibbles from SRAM {R2,R1}.
- `RDataAck`  in  2  requester's read-data acknowledge (11 = both captured).
- `Ack`  out  1  transaction acknowledge.
- `ERR`  out  1  sticky protocol/range error flag.
- `sram_ce`, `sram_we`  out  1 each  one-cycle SRAM strobes.
- `sram_addr`  out  ADDR_W; `sram_wdata`  out  8; `sram_rdata`  in  8.

## Operation
- States: `RTZ`, `IDLE`, `WR`, `WR_HOLD`, `RD_WAIT`, `RD_HOLD`, `RD_RTZ`.
- Reset: state `RTZ`; all outputs 0, `ERR` 0, latency counter 0.
- `RTZ`: wait for `RW==00` (and `RDataAck==00`), then `IDLE`. A request held across reset is never serviced.
- `IDLE`, `RW==01`: latch `A`,{W2,W1}. In range: `sram_ce=sram_we=1` for one cycle → `WR`. Out of range: no strobe, `ERR=1`, still acknowledge.
- `WR` → `WR_HOLD` with `Ack=1`, `WdataAck=11`. In `WR_HOLD`, `RW==00` → `Ack=0`, `WdataAck=00` → `IDLE`.
- `IDLE`, `RW==10`: latch `A`. In range: `sram_ce=1`, `sram_we=0` for one cycle. The counter loads `RD_LAT` → `RD_WAIT`. Out of range: data forced to 0, `ERR=1`.
- `RD_WAIT`: at count expiry, capture `sram_rdata` into {R2,R1}, `Ack=1` → `RD_HOLD`.
- `RD_HOLD`: `RDataAck==11` → `RD_RTZ`. `RW==00` before that: abort, `ERR=1`, `Ack=0`, R cleared → `RTZ`.
- `RD_RTZ`: `RW==00` and `RDataAck==00` → `Ack=0`, `R1=R2=0` → `IDLE`.
- `RW==11` in `IDLE`: ignored, `ERR=1`, remain `IDLE`. `RW` changing value while `Ack=1` (other than to 00): ignored.
- `ERR` clears only on `RST`.

## Timing
- Without sync: `RW` sampled at edge n → strobe high cycle n..n+1.
- Write: `Ack`/`WdataAck` high after edge n+1.
- Read: `Ack` and R data valid after edge n+1+RD_LAT.
- Release: `Ack` falls one edge after qualifying RTZ inputs are sampled.
- Back-to-back: a new request is sampled no earlier than the edge after `Ack` falls.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `MEM_HS_SYNC_EN` defined: `RW`, `RDataAck` pass through 2-flop synchronizers before the FSM. All input-referenced latencies grow by 2 cycles. `A`/`W*` are sampled only after `RW` is seen, so they are stable.
- Undefined: inputs are sampled directly. Requires a synchronous requester.

## Structure
- Package `mem_hs_pkg`: state enum, RW encodings (`RW_IDLE`, `RW_WR`, `RW_RD`, `RW_BAD`), data width 8.
- Sub-module `mem_hs_sync`: parameterized-width 2-flop synchronizer, instantiated only under `MEM_HS_SYNC_EN`.

## Test plan
- Write: `RW=01`, `A=17'h11111`, W1=W2=1 → one strobe, addr 11111, data 8'h11. `Ack`=1, `WdataAck`=11. `RW=00` → both return to 0 one edge later.
- Read, `RD_LAT=2`: after the write, `RW=10`, `A=17'h11111` → `Ack` 3 edges after sample with R1=R2=1. `RDataAck=11`, then `RW=00`/`RDataAck=00` → `Ack`=0, R=0.
- Out of range, `DEPTH=16`: write `A=17'h00020` → no strobe, `Ack`=1, `ERR`=1. Subsequent read returns 0.
- Illegal `RW=11` → no `Ack`, no strobe, `ERR`=1. Next `RW=01` completes normally.
- Reset mid-read with `RW=10` held → outputs 0. No service until `RW=00` is seen. The next read completes.
- Read abort: `RW` drops to 00 while `RDataAck=00` in `RD_HOLD` → `Ack`=0, `ERR`=1, R cleared.
